// File: rtl/cond_pkg.sv
// Shared types for condition evaluation: condition-code enum, flag layout and flag-bank word.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: 16-code condition field against one NZCV flag word.
module cond_eval
  import cond_pkg::*;
(
  input  cond_e  cond,
  input  flags_t flags,
  output logic   cond_ex
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
  end

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      EQ: cond_ex = z;
      NE: cond_ex = !z;
      CS: cond_ex = c;
      CC: cond_ex = !c;
      MI: cond_ex = n;
      PL: cond_ex = !n;
      VS: cond_ex = v;
      VC: cond_ex = !v;
      HI: cond_ex = c && !z;
      LS: cond_ex = !c || z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = !z && (n == v);
      LE: cond_ex = z || (n != v);
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: banked NZCV flags, condition gating of controls, one-stage
// output register with stall and flush.
module cond_unit
  import cond_pkg::*;
#(
  parameter int NUM_SETS = 2,
  parameter int SEL_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [3:0]       cond_i,
  input  logic [SEL_W-1:0] set_sel_i,
  input  logic [3:0]       alu_flags_i,
  input  logic [1:0]       flag_w_i,
  input  logic             reg_write_i,
  input  logic             mem_write_i,
  input  logic             pc_src_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic             cond_ex_o,
  output logic             reg_write_o,
  output logic             mem_write_o,
  output logic             pc_src_o,
  output logic [3:0]       flags_o
);

  flags_t           banks [NUM_SETS];
  logic [SEL_W-1:0] sel;
  flags_t           cur_flags;
  logic             cond_ex;
  logic             admit;
  logic             live;
  logic             pass;

  // Selects beyond the implemented banks alias bank 0.
  always_comb begin
    sel = set_sel_i;
    if (int'(set_sel_i) >= NUM_SETS) sel = '0;
  end

  always_comb begin
    cur_flags = '0;
    for (int unsigned i = 0; i < NUM_SETS; i++) begin
      if (sel == SEL_W'(i)) cur_flags = banks[i];
    end
  end

  assign flags_o = cur_flags;

  cond_eval u_eval (
    .cond    (cond_e'(cond_i)),
    .flags   (cur_flags),
    .cond_ex (cond_ex)
  );

  always_comb begin
    admit = valid_i && !flush_i;
    live  = admit && !stall_i;
    pass  = live && cond_ex;
  end

  // Bank writes land at the edge, so a same-cycle read always sees the pre-update value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SETS; i++) banks[i] <= '0;
      valid_o     <= 1'b0;
      cond_ex_o   <= 1'b0;
      reg_write_o <= 1'b0;
      mem_write_o <= 1'b0;
      pc_src_o    <= 1'b0;
    end else if (!stall_i) begin
      valid_o     <= admit;
      cond_ex_o   <= admit && cond_ex;
      reg_write_o <= pass && reg_write_i;
      mem_write_o <= pass && mem_write_i;
      pc_src_o    <= pass && pc_src_i;
      for (int unsigned i = 0; i < NUM_SETS; i++) begin
        if (pass && sel == SEL_W'(i)) begin
          if (flag_w_i[1]) begin
            banks[i][FLAG_N] <= alu_flags_i[FLAG_N];
            banks[i][FLAG_Z] <= alu_flags_i[FLAG_Z];
          end
          if (flag_w_i[0]) begin
            banks[i][FLAG_C] <= alu_flags_i[FLAG_C];
            banks[i][FLAG_V] <= alu_flags_i[FLAG_V];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: a reference flag-bank model predicts each registered
// output set and the combinational flag view.
module tb_cond_unit;

  localparam int NUM_SETS = 2;
  localparam int SEL_W    = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_i;
  logic [3:0]       cond_i;
  logic [SEL_W-1:0] set_sel_i;
  logic [3:0]       alu_flags_i;
  logic [1:0]       flag_w_i;
  logic             reg_write_i, mem_write_i, pc_src_i;
  logic             stall_i, flush_i;
  logic             valid_o, cond_ex_o, reg_write_o, mem_write_o, pc_src_o;
  logic [3:0]       flags_o;

  cond_unit #(.NUM_SETS(NUM_SETS), .SEL_W(SEL_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (valid_i),
    .cond_i      (cond_i),
    .set_sel_i   (set_sel_i),
    .alu_flags_i (alu_flags_i),
    .flag_w_i    (flag_w_i),
    .reg_write_i (reg_write_i),
    .mem_write_i (mem_write_i),
    .pc_src_i    (pc_src_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .cond_ex_o   (cond_ex_o),
    .reg_write_o (reg_write_o),
    .mem_write_o (mem_write_o),
    .pc_src_o    (pc_src_o),
    .flags_o     (flags_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic valid;
    logic cond_ex;
    logic rw;
    logic mw;
    logic pc;
  } out_t;

  out_t       sb_q[$];
  out_t       last_exp;
  logic [3:0] mbank [NUM_SETS];
  int         total  = 0;
  int         passed = 0;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
  endtask

  // Conditions come in true/inverted pairs; bit 0 selects the inverse.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, base;
    {n, z, cc, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  task automatic compare_out(input string tag);
    out_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 4'd1, 4'd0);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_valid"},   {3'b0, valid_o},     {3'b0, e.valid});
    check({tag, "_cond_ex"}, {3'b0, cond_ex_o},   {3'b0, e.cond_ex});
    check({tag, "_rw"},      {3'b0, reg_write_o}, {3'b0, e.rw});
    check({tag, "_mw"},      {3'b0, mem_write_o}, {3'b0, e.mw});
    check({tag, "_pc"},      {3'b0, pc_src_o},    {3'b0, e.pc});
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; valid_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
    cond_i = 4'hE; flag_w_i = 2'b11; alu_flags_i = 4'hF;
    reg_write_i = 1'b1; mem_write_i = 1'b1; pc_src_i = 1'b1;
    for (int i = 0; i < NUM_SETS; i++) mbank[i] = 4'h0;
    last_exp = '0;
    sb_q.push_back('0);
    @(posedge clk); #1;
    reset = 1'b0;
    compare_out(tag);
    stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
  endtask

  task automatic issue(input string tag, input logic v, input logic [3:0] c, input int sel,
                       input logic [3:0] alu, input logic [1:0] fw,
                       input logic rw, input logic mw, input logic pc,
                       input logic st, input logic fl);
    logic [3:0] cur;
    logic ce, admit, pass;
    out_t e;
    valid_i = v; cond_i = c; set_sel_i = SEL_W'(sel); alu_flags_i = alu; flag_w_i = fw;
    reg_write_i = rw; mem_write_i = mw; pc_src_i = pc; stall_i = st; flush_i = fl;
    cur   = mbank[sel];
    ce    = model_cond(c, cur);
    admit = v & ~fl;
    pass  = admit & ~st & ce;
    if (st) e = last_exp;
    else    e = '{valid: admit, cond_ex: admit & ce, rw: pass & rw, mw: pass & mw, pc: pass & pc};
    sb_q.push_back(e);
    last_exp = e;
    #1;
    check({tag, "_flags"}, flags_o, cur);
    if (pass) begin
      if (fw[1]) mbank[sel][3:2] = alu[3:2];
      if (fw[0]) mbank[sel][1:0] = alu[1:0];
    end
    @(posedge clk); #1;
    compare_out(tag);
  endtask

  initial begin
    set_sel_i = '0;
    @(negedge clk);
    do_reset("reset");

    // EQ on cleared flags, then set Z and retry
    issue("eq0",   1, 4'h0, 0, 4'h0, 2'b00, 1, 0, 0, 0, 0);
    issue("wr_z",  1, 4'hE, 0, 4'h4, 2'b11, 0, 0, 0, 0, 0);
    issue("eq1",   1, 4'h0, 0, 4'h0, 2'b00, 1, 1, 1, 0, 0);

    // per-half writes
    issue("set_f", 1, 4'hE, 0, 4'hF, 2'b11, 0, 0, 0, 0, 0);
    issue("w_nz",  1, 4'hE, 0, 4'h0, 2'b10, 0, 0, 0, 0, 0);
    issue("w_cv",  1, 4'hE, 0, 4'h0, 2'b01, 0, 0, 0, 0, 0);
    issue("idle",  0, 4'hE, 0, 4'h0, 2'b00, 0, 0, 0, 0, 0);

    // back-to-back: k+1 sees k's flags with no bubble
    issue("b2b_k",  1, 4'hE, 0, 4'h4, 2'b11, 0, 0, 0, 0, 0);
    issue("b2b_k1", 1, 4'h1, 0, 4'h0, 2'b00, 1, 0, 0, 0, 0);

    // bank isolation
    issue("clr0",  1, 4'hE, 0, 4'h0, 2'b11, 0, 0, 0, 0, 0);
    issue("wr1",   1, 4'hE, 1, 4'h8, 2'b11, 0, 0, 0, 0, 0);
    issue("lt_b1", 1, 4'hB, 1, 4'h0, 2'b00, 1, 0, 1, 0, 0);
    issue("lt_b0", 1, 4'hB, 0, 4'h0, 2'b00, 1, 0, 1, 0, 0);
    issue("gt_b0", 1, 4'hC, 0, 4'h0, 2'b00, 1, 1, 0, 0, 0);

    // stall holds outputs and blocks flag writes, flush squashes
    issue("pre_st", 1, 4'hE, 0, 4'h0, 2'b00, 1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      issue("stall", 1, 4'hE, 0, 4'hF, 2'b11, 0, 0, 0, 1, 0);
    issue("st_fl", 1, 4'hE, 0, 4'hF, 2'b11, 0, 0, 0, 1, 1);
    issue("flush", 1, 4'hE, 0, 4'hF, 2'b11, 1, 1, 1, 0, 1);
    issue("post",  1, 4'h0, 0, 4'h0, 2'b00, 0, 0, 0, 0, 0);

    // sweep every code against every flag value, alternating banks
    for (int f = 0; f < 16; f++) begin
      issue("sw_set", 1, 4'hE, f % 2, 4'(f), 2'b11, 0, 0, 0, 0, 0);
      for (int c = 0; c < 16; c++)
        issue("sweep", 1, 4'(c), f % 2, 4'($urandom_range(15)), 2'b00,
              1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 0, 0);
    end

    // random mix including stalls, flushes and flag writes
    for (int k = 0; k < 200; k++)
      issue("rand", 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom_range(1),
            4'($urandom_range(15)), 2'($urandom_range(3)),
            1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            ($urandom_range(5) == 0), ($urandom_range(5) == 0));

    // reset mid-stream drops the in-flight instruction
    issue("pre_rst", 1, 4'hE, 1, 4'hF, 2'b11, 1, 1, 1, 0, 0);
    do_reset("rst_mid");
    issue("after",  1, 4'h0, 1, 4'h0, 2'b00, 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
